// File: rtl/alu_req_scheduler_if.sv
// Requester-side and ALU-side signal bundle for alu_req_scheduler.
// master = scheduler view, slave = requesters plus ALU view.
interface alu_req_scheduler_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_opcode;
    logic [N*NREQ-1:0] req_a;
    logic [N*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_grant;

    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [2*N-1:0]    rsp_result;
    logic [4:0]        rsp_flags;
    logic              busy;

    logic              alu_start;
    logic [3:0]        alu_opcode;
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic              alu_ready;
    logic [2*N-1:0]    alu_result;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic              alu_s;
    logic              alu_e;

    modport master (
        input  req_valid, req_opcode, req_a, req_b,
        output req_grant,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        output alu_start, alu_opcode, alu_a, alu_b,
        input  alu_ready, alu_result, alu_z, alu_c, alu_v, alu_s, alu_e
    );

    modport slave (
        output req_valid, req_opcode, req_a, req_b,
        input  req_grant,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        input  alu_start, alu_opcode, alu_a, alu_b,
        output alu_ready, alu_result, alu_z, alu_c, alu_v, alu_s, alu_e
    );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one signed N-bit ALU between NREQ requesters.
// Optional macro ALU_SCHED_TIMEOUT_EN aborts WAIT after TIMEOUT cycles with an E-only response.
module alu_req_scheduler #(
    parameter int unsigned N       = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_req_scheduler_if.master bus
);
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 2 * N;
    localparam int unsigned FLG_W = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FLAGS = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   sel_id;
    logic              sel_hit;
    logic [NREQ-1:0]   grant_c;

    logic              grant_en;
    logic              cap_en;
    logic              rsp_load;

    logic [ID_W-1:0]   id_q;
    logic [OP_W-1:0]   op_q;
    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;

    logic              start_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [RES_W-1:0]  rsp_result_q;
    logic [FLG_W-1:0]  rsp_flags_q;

    logic [RES_W-1:0]  cap_result_q;
    logic              cap_c_q;
    logic              cap_v_q;
    logic              cap_e_q;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              tmo_load;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    // Cyclic offset from the round-robin pointer, valid for any NREQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return ID_W'(sum);
    endfunction

    // First pending requester at or after the pointer.
    always_comb begin
        sel_hit = 1'b0;
        sel_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!sel_hit && bus.req_valid[rr_index(ptr_q, k)]) begin
                sel_hit = 1'b1;
                sel_id  = rr_index(ptr_q, k);
            end
        end
    end

    // Grant is the only combinational output: it must answer req_valid in the same cycle.
    always_comb begin
        grant_c = '0;
        if (grant_en) grant_c[sel_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        cap_en   = 1'b0;
        rsp_load = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
        tmo_load = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sel_hit && !rst) begin
                    grant_en = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.alu_ready) begin
                    cap_en  = 1'b1;
                    state_d = S_FLAGS;
                end
`ifdef ALU_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_load = 1'b1;
                    state_d  = S_RESP;
                end
`endif
            end
            // Z and S settle one cycle after alu_ready, so they are taken here.
            S_FLAGS: begin
                rsp_load = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and pointer advance; latched operands hold until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            id_q  <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (grant_en) begin
            ptr_q <= (32'(sel_id) == NREQ - 1) ? '0 : sel_id + ID_W'(1);
            id_q  <= sel_id;
            op_q  <= bus.req_opcode[32'(sel_id) * OP_W +: OP_W];
            a_q   <= bus.req_a[32'(sel_id) * N +: N];
            b_q   <= bus.req_b[32'(sel_id) * N +: N];
        end
    end

    // Handshake strobes registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            start_q     <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_result_q <= '0;
            cap_c_q      <= 1'b0;
            cap_v_q      <= 1'b0;
            cap_e_q      <= 1'b0;
        end else if (cap_en) begin
            cap_result_q <= bus.alu_result;
            cap_c_q      <= bus.alu_c;
            cap_v_q      <= bus.alu_v;
            cap_e_q      <= bus.alu_e;
        end
    end

    // Response fields only change on entry to RESP and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else if (rsp_load) begin
            rsp_id_q     <= id_q;
            rsp_result_q <= cap_result_q;
            rsp_flags_q  <= {cap_e_q, bus.alu_s, cap_v_q, cap_c_q, bus.alu_z};
        end
`ifdef ALU_SCHED_TIMEOUT_EN
        else if (tmo_load) begin
            rsp_id_q     <= id_q;
            rsp_result_q <= '0;
            rsp_flags_q  <= FLG_W'(5'b10000);
        end
`endif
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    // Counts WAIT cycles; cleared in ISSUE so each WAIT starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_cnt_q <= '0;
        else if (state_q == S_ISSUE) tmo_cnt_q <= '0;
        else if (state_q == S_WAIT)  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
`endif

    assign bus.req_grant  = grant_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.busy       = busy_q;
    assign bus.alu_start  = start_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler with a small behavioural ALU model.
// Timeout scenario runs only when ALU_SCHED_TIMEOUT_EN is defined.
module tb_alu_req_scheduler;
    localparam int unsigned N       = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_BAD = 4'hF;

    logic clk = 1'b0;
    logic rst;

    alu_req_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

    alu_req_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [3:0] op; logic [7:0] a; logic [7:0] b; } iss_t;
    typedef struct { int id; logic [15:0] res; logic [4:0] flg; } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t cur_iss;
    iss_t gi;
    rsp_t gr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_grant = -100;
    int last_start = -100;
    int grant_cnt  = 0;
    int rsp_cnt    = 0;
    bit spacing_chk = 1'b0;
    bit lat_chk     = 1'b1;
    bit tmo_chk     = 1'b0;
    int alu_lat     = 1;
    bit alu_mute    = 1'b0;

    int req_tick [NREQ] = '{default: 0};
    int gnt_tick [NREQ] = '{default: 0};
    int drop_tick[NREQ] = '{default: 0};
    logic [NREQ-1:0] g_seen;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A request stays pending until granted or explicitly withdrawn.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            bus.req_valid[i] = (req_tick[i] - gnt_tick[i] - drop_tick[i]) > 0;
    end

    always @(negedge clk) begin
        g_seen = bus.req_grant;
        if (g_seen != '0) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (g_seen[i]) gnt_tick[i]++;
        end
    end

    // Grant monitor: order, one-hot, idle-only, spacing.
    always @(negedge clk) begin
        if (bus.req_grant != '0) begin
            chk("grant_while_busy", 32'(bus.busy), 32'd0);
            if (iss_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_unexpected: got grant %b, expected none", bus.req_grant);
            end else begin
                gi = iss_q.pop_front();
                chk("grant_id", 32'(bus.req_grant), 32'd1 << gi.id);
                cur_iss = gi;
            end
            if (spacing_chk && grant_cnt > 0) chk("grant_spacing", cyc - last_grant, 32'd5);
            last_grant = cyc;
            grant_cnt++;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp id %0d result 0x%0h, expected none",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                gr = rsp_q.pop_front();
                chk("rsp_id",     32'(bus.rsp_id),     gr.id);
                chk("rsp_result", 32'(bus.rsp_result), 32'(gr.res));
                chk("rsp_flags",  32'(bus.rsp_flags),  32'(gr.flg));
                if (lat_chk) chk("rsp_latency", cyc - last_start, 32'd3);
                if (tmo_chk) chk("rsp_timeout_latency", cyc - last_start, TIMEOUT + 1);
            end
            rsp_cnt++;
        end
    end

    function automatic void alu_eval(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [15:0] r, output logic c, output logic v,
                                     output logic e);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [8:0] u;
        logic [7:0] d;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (op)
            OP_ADD: begin
                r = sa + sb;
                u = {1'b0, a} + {1'b0, b};
                c = u[8];
                v = (a[7] == b[7]) && (u[7] != a[7]);
            end
            OP_SUB: begin
                r = sa - sb;
                d = a - b;
                c = a < b;
                v = (a[7] != b[7]) && (d[7] != a[7]);
            end
            OP_MUL: r = sa * sb;
            OP_DIV: begin
                if (b == 8'd0) e = 1'b1;
                else           r = sa / sb;
            end
            default: e = 1'b1;
        endcase
    endfunction

    // ALU model: ready alu_lat cycles after start; Z/S show stale values in the ready cycle.
    initial begin : alu_model
        logic [15:0] r;
        logic c, v, e;
        bus.alu_ready = 1'b0; bus.alu_result = '0;
        bus.alu_z = 1'b0; bus.alu_c = 1'b0; bus.alu_v = 1'b0; bus.alu_s = 1'b0; bus.alu_e = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                chk("start_latency", cyc - last_grant, 32'd1);
                chk("alu_opcode", 32'(bus.alu_opcode), 32'(cur_iss.op));
                chk("alu_a",      32'(bus.alu_a),      32'(cur_iss.a));
                chk("alu_b",      32'(bus.alu_b),      32'(cur_iss.b));
                last_start = cyc;
                alu_eval(bus.alu_opcode, bus.alu_a, bus.alu_b, r, c, v, e);
                if (!alu_mute) begin
                    repeat (alu_lat) @(posedge clk);
                    #1;
                    bus.alu_ready = 1'b1; bus.alu_result = r;
                    bus.alu_c = c; bus.alu_v = v; bus.alu_e = e;
                    bus.alu_z = !(r == 16'd0); bus.alu_s = !r[15];
                    @(posedge clk);
                    #1;
                    bus.alu_ready = 1'b0;
                    bus.alu_z = (r == 16'd0); bus.alu_s = r[15];
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_opcode[4*id +: 4] = op;
        bus.req_a[8*id +: 8]      = a;
        bus.req_b[8*id +: 8]      = b;
        req_tick[id]++;
    endtask

    task automatic expect_op(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] res, input logic [4:0] flg);
        iss_q.push_back('{id: id, op: op, a: a, b: b});
        rsp_q.push_back('{id: id, res: res, flg: flg});
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (grant_cnt < n && k < budget) begin @(posedge clk); k++; end
        n_checks++;
        if (grant_cnt < n) begin
            n_fail++;
            $display("FAIL wait_grants: got %0d grants, expected %0d", grant_cnt, n);
        end
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int k = 0;
        while (rsp_cnt < n && k < budget) begin @(posedge clk); k++; end
        n_checks++;
        if (rsp_cnt < n) begin
            n_fail++;
            $display("FAIL wait_rsps: got %0d responses, expected %0d", rsp_cnt, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy),       32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),  32'd0);
        chk("rst_alu_start", 32'(bus.alu_start),  32'd0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags),  32'd0);

        // All four pending out of reset: grants 0,1,2,3 spaced by 5, then 0 again.
        #1;
        expect_op(0, OP_ADD, 8'd1,   8'd2, 16'h0003, 5'b00000); set_req(0, OP_ADD, 8'd1,   8'd2);
        expect_op(1, OP_SUB, 8'd2,   8'd5, 16'hFFFD, 5'b01010); set_req(1, OP_SUB, 8'd2,   8'd5);
        expect_op(2, OP_MUL, 8'd3,   8'd3, 16'h0009, 5'b00000); set_req(2, OP_MUL, 8'd3,   8'd3);
        expect_op(3, OP_ADD, 8'd127, 8'd1, 16'h0080, 5'b00100); set_req(3, OP_ADD, 8'd127, 8'd1);
        #1;
        chk("rst_grant_gated", 32'(bus.req_grant), 32'd0);
        spacing_chk = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        wait_grants(4, 40);
        @(posedge clk); #2;
        expect_op(0, OP_SUB, 8'd7,    8'd7,    16'h0000, 5'b00001); set_req(0, OP_SUB, 8'd7,    8'd7);
        expect_op(1, OP_DIV, 8'd10,   8'd0,    16'h0000, 5'b10001); set_req(1, OP_DIV, 8'd10,   8'd0);
        expect_op(2, OP_MUL, 8'hFC,   8'd3,    16'hFFF4, 5'b01000); set_req(2, OP_MUL, 8'hFC,   8'd3);
        expect_op(3, OP_BAD, 8'h55,   8'hAA,   16'h0000, 5'b10001); set_req(3, OP_BAD, 8'h55,   8'hAA);
        wait_grants(8, 60);
        spacing_chk = 1'b0;
        wait_rsps(8, 40);

        // Single op from pointer 0.
        @(posedge clk); #2;
        expect_op(0, OP_ADD, 8'd5, 8'd3, 16'h0008, 5'b00000); set_req(0, OP_ADD, 8'd5, 8'd3);
        wait_rsps(9, 30);

        // Pointer is 1: requester 2 wins over requester 0.
        @(posedge clk); #2;
        expect_op(2, OP_ADD, 8'hFF, 8'h01, 16'h0000, 5'b00011);
        expect_op(0, OP_ADD, 8'h80, 8'h80, 16'hFF00, 5'b01110);
        set_req(0, OP_ADD, 8'h80, 8'h80);
        set_req(2, OP_ADD, 8'hFF, 8'h01);
        wait_rsps(11, 40);

        // Requester 3 raises and withdraws while the scheduler is busy.
        @(posedge clk); #2;
        expect_op(1, OP_ADD, 8'd2, 8'd2, 16'h0004, 5'b00000); set_req(1, OP_ADD, 8'd2, 8'd2);
        wait_grants(12, 20);
        @(posedge clk); #2;
        set_req(3, OP_ADD, 8'd9, 8'd9);
        repeat (2) @(posedge clk);
        #2 drop_tick[3]++;
        wait_rsps(12, 30);
        repeat (8) @(posedge clk);

        // Reset while waiting on a slow ALU: no response for that op.
        alu_lat = 4;
        lat_chk = 1'b0;
        @(posedge clk); #2;
        iss_q.push_back('{id: 2, op: OP_ADD, a: 8'd1, b: 8'd1});
        set_req(2, OP_ADD, 8'd1, 8'd1);
        wait_grants(13, 20);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy",       32'(bus.busy),       32'd0);
        chk("midrst_alu_start",  32'(bus.alu_start),  32'd0);
        chk("midrst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("midrst_alu_a",      32'(bus.alu_a),      32'd0);
        chk("midrst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("midrst_rsp_id",     32'(bus.rsp_id),     32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        alu_lat = 1;
        lat_chk = 1'b1;

        // Pointer back at 0 after reset; only requester 3 pending.
        @(posedge clk); #2;
        expect_op(3, OP_SUB, 8'd3, 8'd5, 16'hFFFE, 5'b01010); set_req(3, OP_SUB, 8'd3, 8'd5);
        wait_rsps(13, 30);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rsp_result", 32'(bus.rsp_result), 32'h0000FFFE);
        chk("hold_rsp_flags",  32'(bus.rsp_flags),  32'b01010);
        chk("hold_rsp_id",     32'(bus.rsp_id),     32'd3);
        chk("hold_alu_opcode", 32'(bus.alu_opcode), 32'(OP_SUB));
        chk("hold_alu_b",      32'(bus.alu_b),      32'd5);

`ifdef ALU_SCHED_TIMEOUT_EN
        alu_mute = 1'b1;
        lat_chk  = 1'b0;
        tmo_chk  = 1'b1;
        @(posedge clk); #2;
        expect_op(0, OP_ADD, 8'd1, 8'd1, 16'h0000, 5'b10000); set_req(0, OP_ADD, 8'd1, 8'd1);
        wait_rsps(14, 60);
        tmo_chk  = 1'b0;
        alu_mute = 1'b0;
        lat_chk  = 1'b1;
`endif

        repeat (4) @(posedge clk);
        chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
